pipe_stage_latch: RTL

Parametrised, elastic successor to the fixed inter-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one opaque data payload plus a control bundle between two stages with a valid/ready handshake, synchronous flush, and bubble zeroing of control. An optional 2-entry skid buffer breaks the combinational ready path. A saturating stall counter supports performance debug.

---
 rtl/pipe_stage_latch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_latch.sv
// Elastic inter-stage pipeline latch: one data payload plus a control bundle
// carried between two stages over a valid/ready handshake. It supports a
// synchronous flush, zeroes control on bubbles, and can add a 2-entry skid
// buffer. A saturating stall counter is included for performance debug.
//
// Handshake: a beat moves on a rising edge when valid and ready are both high
// on that side (accept = in_valid & in_ready, emit = out_valid & out_ready).
// A valid beat that is not taken is not the latch's concern; upstream must
// hold it. in_ready never depends on in_valid. With SKID=1, in_ready is a pure
// register output (!skid_valid) with no path from out_ready.
module pipe_stage_latch #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // HEAD drives the outputs; SKID holds a second beat while HEAD is stalled.
  logic              head_valid, head_valid_nxt;
  logic [DATA_W-1:0] head_data,  head_data_nxt;
  logic [CTRL_W-1:0] head_ctrl,  head_ctrl_nxt;
  logic              skid_valid, skid_valid_nxt;
  logic [DATA_W-1:0] skid_data,  skid_data_nxt;
  logic [CTRL_W-1:0] skid_ctrl,  skid_ctrl_nxt;
  logic [CNT_W-1:0]  stall_nxt;
  logic              accept, emit;

  // Without a skid entry, HEAD can only refill when it is empty or draining.
  assign in_ready  = (SKID != 0) ? !skid_valid : (!head_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign emit      = head_valid & out_ready;

  assign out_valid = head_valid;
  assign out_data  = head_data;
  assign out_ctrl  = head_ctrl;
  assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

  // Entry update: flush first, then move beats in strict FIFO order.
  always_comb begin
    head_valid_nxt = head_valid;
    head_data_nxt  = head_data;
    head_ctrl_nxt  = head_ctrl;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    skid_ctrl_nxt  = skid_ctrl;
    if (flush) begin
      head_valid_nxt = 1'b0;
      head_data_nxt  = '0;
      head_ctrl_nxt  = '0;
      skid_valid_nxt = 1'b0;
      skid_data_nxt  = '0;
      skid_ctrl_nxt  = '0;
    end else if (skid_valid) begin
      // in_ready is low here, so only the SKID-to-HEAD move can happen.
      if (emit) begin
        head_data_nxt  = skid_data;
        head_ctrl_nxt  = skid_ctrl;
        skid_valid_nxt = 1'b0;
        skid_data_nxt  = '0;
        skid_ctrl_nxt  = '0;
      end
    end else if (!head_valid) begin
      if (accept) begin
        head_valid_nxt = 1'b1;
        head_data_nxt  = in_data;
        head_ctrl_nxt  = in_ctrl;
      end
    end else if (emit) begin
      if (accept) begin
        head_data_nxt = in_data;
        head_ctrl_nxt = in_ctrl;
      end else begin
        // Bubble: control goes inert, data is left stable.
        head_valid_nxt = 1'b0;
        head_ctrl_nxt  = '0;
      end
    end else if (accept && (SKID != 0)) begin
      skid_valid_nxt = 1'b1;
      skid_data_nxt  = in_data;
      skid_ctrl_nxt  = in_ctrl;
    end
  end

  // Stall counter: a held beat refused downstream, saturating, kept on flush.
  always_comb begin
    stall_nxt = stall_cnt;
    if (!flush && head_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_nxt = stall_cnt + CNT_W'(1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      head_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      stall_cnt  <= '0;
    end else begin
      head_valid <= head_valid_nxt;
      head_data  <= head_data_nxt;
      head_ctrl  <= head_ctrl_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      skid_ctrl  <= skid_ctrl_nxt;
      stall_cnt  <= stall_nxt;
    end
  end

endmodule
